uart_rx_deserializer: RTL

Receive half of the software-defined UART. Oversamples an asynchronous serial line, recovers 8N1 frames (optionally with parity), and delivers each received word as a parallel `data` bus qualified by a one-cycle `ld` strobe. The `ld` strobe drives the load-enable of the downstream N-bit holding register directly. It is the serial-to-parallel counterpart of the transmit path.

---
 rtl/uart_rx_deserializer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-flop sync, mid-bit sampling; ld/frame_err/parity_err strobe one cycle after the stop sample.
// No backpressure (data holds until next ld); UART_RX_PARITY_EN adds an even parity bit between data and stop.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 ld,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   ld_q, ld_d;
    logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   perr_q, perr_d;
`endif

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            ld_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            ld_q    <= ld_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        ld_d    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // Mid-start sample: a line back high here was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
                    idx_d = idx_q + IW'(1);
                    if (idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = (^sh_q) ^ rx_s;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = sh_q;
                        ld_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are masked during clear so a pending pulse never overlaps it.
    assign data      = data_q;
    assign ld        = ld_q & ~clear;
    assign frame_err = ferr_q & ~clear;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q & ~clear;
`else
    assign parity_err = 1'b0;
`endif

endmodule
